// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared types, constants and helpers for serial_alu
//
// Contents:
//   state_t      FSM state encoding (IDLE, RUN, FIN)
//   OP_ADD/SUB   values of the ctrl input
//   slice_count  number of RUN cycles for a WIDTH/SLICE pair
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_count(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE-bit ripple-carry adder
//
// Ports:
//   a, b   in  [SLICE-1:0]  operand slices (b already inverted for subtract)
//   cin    in  1            carry into bit 0
//   sum    out [SLICE-1:0]  slice sum
//   cout   out 1            carry out of the slice MSB
//   cmsb   out 1            carry into the slice MSB (overflow detection)
module alu_slice #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  // Ripple through full-adder bits; a block-local carry avoids a
  // self-referencing carry vector.
  always_comb begin
    logic c;
    c    = cin;
    sum  = '0;
    cmsb = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      cmsb   = c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - multi-cycle add/subtract unit, SLICE bits per clock
//
// Optional feature: define SERIAL_ALU_SAT_EN to clamp ans on signed overflow.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled when not busy (IDLE or FIN)
//   a, b   in   WIDTH  operands, latched on accept
//   cin    in   1      carry in (add) / borrow in (sub), latched on accept
//   ctrl   in   1      OP_ADD / OP_SUB, latched on accept
//   busy   out  1      operation in flight
//   done   out  1      one-cycle result-valid pulse
//   ans    out  WIDTH  result, held until the next done
//   cout   out  1      final carry (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow
//   zero   out  1      ans == 0
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = slice_count(WIDTH, SLICE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh;   // operand A going out the bottom, sum coming in the top
  logic [WIDTH-1:0] b_sh;   // operand B, pre-inverted for subtract
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] s_sum;
  logic             s_cout, s_cmsb;

  logic             accept, last;
  logic [WIDTH-1:0] a_nx, fin_ans;
  logic             fin_ovf;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sh[SLICE-1:0]),
    .b    (b_sh[SLICE-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .cmsb (s_cmsb)
  );

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  // Once all N slices have been consumed, a_sh holds the full result.
  assign a_nx    = (a_sh >> SLICE) | (WIDTH'(s_sum) << (WIDTH - SLICE));
  assign fin_ovf = s_cmsb ^ s_cout;

`ifdef SERIAL_ALU_SAT_EN
  // Overflow always flips the sign bit, so a raw negative result means the
  // true value was too positive, and vice versa.
  always_comb begin
    fin_ans = a_nx;
    if (fin_ovf)
      fin_ans = a_nx[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign fin_ans = a_nx;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? FIN : RUN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      ans   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + ~CIN: fold both inversions in at latch time.
      a_sh  <= a;
      b_sh  <= (ctrl == OP_SUB) ? ~b : b;
      carry <= (ctrl == OP_SUB) ? ~cin : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_nx;
      b_sh  <= b_sh >> SLICE;
      carry <= s_cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        ans  <= fin_ans;
        cout <= s_cout;
        ovf  <= fin_ovf;
        zero <= (fin_ans == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - self-checking bench for serial_alu (SLICE=1 and SLICE=4)
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [2];
  logic [7:0] a_v     [2];
  logic [7:0] b_v     [2];
  logic       cin_v   [2];
  logic       ctrl_v  [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [7:0] ans_v   [2];
  logic       cout_v  [2];
  logic       ovf_v   [2];
  logic       zero_v  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .ctrl(ctrl_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .ans(ans_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  serial_alu #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .ctrl(ctrl_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .ans(ans_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cycles_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic. Returns {zero, ovf, cout, ans}.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sub);
    int ua, ub, sa, sb, ures, sres;
    logic [7:0] r;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      ures = ua + ub + int'(ci);
      sres = sa + sb + int'(ci);
      co   = (ures > 255);
    end else begin
      ures = ua - ub - int'(ci);
      sres = sa - sb - int'(ci);
      co   = (ures >= 0);
    end
    r  = ures[7:0];
    ov = (sres > 127) || (sres < -128);
`ifdef SERIAL_ALU_SAT_EN
    if (sres > 127)       r = 8'h7F;
    else if (sres < -128) r = 8'h80;
`endif
    return {(r == 8'h00), ov, co, r};
  endfunction

  task automatic check_result(input string tag, input int d, input logic [10:0] e);
    check({tag, ".ans"},  32'(ans_v[d]),  32'(e[7:0]));
    check({tag, ".cout"}, 32'(cout_v[d]), 32'(e[8]));
    check({tag, ".ovf"},  32'(ovf_v[d]),  32'(e[9]));
    check({tag, ".zero"}, 32'(zero_v[d]), 32'(e[10]));
  endtask

  task automatic do_op(input string tag, input int d, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic sub);
    logic [10:0] e;
    int cyc, bz;
    e = model(a, b, ci, sub);
    @(negedge clk);
    start_v[d] = 1'b1; a_v[d] = a; b_v[d] = b; cin_v[d] = ci; ctrl_v[d] = sub;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    a_v[d] = 8'($urandom); b_v[d] = 8'($urandom);
    cin_v[d] = 1'($urandom); ctrl_v[d] = 1'($urandom);
    cyc = 0; bz = 0;
    while (!done_v[d] && cyc < 40) begin
      if (busy_v[d]) bz++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(cycles_of(d)));
    check({tag, ".busy_cycles"}, 32'(bz), 32'(cycles_of(d)));
    check({tag, ".busy_at_done"}, 32'(busy_v[d]), 32'd0);
    check_result(tag, d, e);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done_v[d]), 32'd0);
  endtask

  initial begin
    logic [10:0] e1, e2;
    int cyc, c2, pulses;
    logic busy_seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0; ctrl_v[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset.busy", 32'(busy_v[d]), 32'd0);
      check("reset.done", 32'(done_v[d]), 32'd0);
      check("reset.flags", {29'd0, cout_v[d], ovf_v[d], zero_v[d]}, 32'd0);
      check("reset.ans", 32'(ans_v[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_0f_01",  0, 8'h0F, 8'h01, 1'b0, 1'b0);
    do_op("add_7f_01",  0, 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("sub_05_05",  0, 8'h05, 8'h05, 1'b0, 1'b1);
    do_op("sub_00_01",  0, 8'h00, 8'h01, 1'b0, 1'b1);
    do_op("sub_80_01",  0, 8'h80, 8'h01, 1'b0, 1'b1);
    do_op("s4_add_ff_01", 1, 8'hFF, 8'h01, 1'b1, 1'b0);
    do_op("s4_sub_80_7f", 1, 8'h80, 8'h7F, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++)
      do_op($sformatf("rnd%0d", i), i % 2, 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));

    // Second START during RUN must be ignored.
    e1 = model(8'h3C, 8'h21, 1'b0, 1'b0);
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h3C; b_v[0] = 8'h21; cin_v[0] = 1'b0; ctrl_v[0] = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    while (!done_v[0] && cyc < 40) begin
      start_v[0] = (cyc == 3);
      if (cyc == 3) begin
        a_v[0] = 8'hAA; b_v[0] = 8'h55; cin_v[0] = 1'b1; ctrl_v[0] = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v[0] = 1'b0;
    check("ignore.lat", 32'(cyc), 32'd8);
    check_result("ignore", 0, e1);
    @(posedge clk); #1;
    check("ignore.idle_busy", 32'(busy_v[0]), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; ctrl_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy_v[0]), 32'd0);
    check("abort.ans", 32'(ans_v[0]), 32'd0);
    check("abort.done", 32'(done_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) pulses++;
    end
    check("abort.no_done", 32'(pulses), 32'd0);
    check("abort.ans_hold", 32'(ans_v[0]), 32'd0);

    // Back-to-back on SLICE=4 with START held through the DONE cycle.
    e1 = model(8'hFF, 8'h01, 1'b1, 1'b0);
    e2 = model(8'h40, 8'h50, 1'b0, 1'b0);
    @(negedge clk);
    start_v[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'h01; cin_v[1] = 1'b1; ctrl_v[1] = 1'b0;
    @(posedge clk); #1;
    a_v[1] = 8'h40; b_v[1] = 8'h50; cin_v[1] = 1'b0; ctrl_v[1] = 1'b0;
    cyc = 0;
    while (!done_v[1] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b.lat1", 32'(cyc), 32'd2);
    check_result("b2b.op1", 1, e1);
    c2 = 0;
    busy_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      c2++;
      if (c2 == 1) begin
        busy_seen = busy_v[1];
        start_v[1] = 1'b0;
      end
    end while (!done_v[1] && c2 < 40);
    check("b2b.reaccept", 32'(busy_seen), 32'd1);
    check("b2b.period", 32'(c2), 32'd3);
    check_result("b2b.op2", 1, e2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
